// File: rtl/heap_pq_ctrl_if.sv
// heap_pq_ctrl_if: request/response and RAM bus of the heap priority queue.
//   slave  : seen by the heap controller (takes enq/deq/kvi and mem_rd,
//            drives kvo/full/empty/busy and the RAM address/write signals)
//   master : seen by the client plus RAM side (the mirror image)
interface heap_pq_ctrl_if #(
  parameter int KEY_W       = 8,
  parameter int VAL_W       = 8,
  parameter int PQ_CAPACITY = 15
);
  localparam int W  = KEY_W + VAL_W;
  localparam int AW = $clog2(PQ_CAPACITY + 1);

  logic          enq;
  logic          deq;
  logic [W-1:0]  kvi;
  logic [W-1:0]  kvo;
  logic          full;
  logic          empty;
  logic          busy;
  logic [AW-1:0] mem_ra;
  logic [W-1:0]  mem_rd;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [W-1:0]  mem_wd;

  modport slave (
    input  enq, deq, kvi, mem_rd,
    output kvo, full, empty, busy, mem_ra, mem_we, mem_wa, mem_wd
  );

  modport master (
    output enq, deq, kvi, mem_rd,
    input  kvo, full, empty, busy, mem_ra, mem_we, mem_wa, mem_wd
  );
endinterface

// File: rtl/heap_pq_ctrl.sv
// heap_pq_ctrl: sequencer for a binary min-heap kept in an external RAM with
// one synchronous read port (data one cycle after mem_ra) and one write port.
// The root entry is mirrored in a register so kvo is always current when idle.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : enq/deq/kvi requests, kvo/full/empty/busy status,
//                 mem_ra/mem_rd read port, mem_we/mem_wa/mem_wd write port
module heap_pq_ctrl #(
  parameter int KEY_W       = 8,
  parameter int VAL_W       = 8,
  parameter int PQ_CAPACITY = 15
) (
  input  logic           clk,
  input  logic           rst,
  heap_pq_ctrl_if.slave  bus
);
  localparam int W  = KEY_W + VAL_W;
  localparam int AW = $clog2(PQ_CAPACITY + 1);
  localparam logic [AW-1:0] ROOT = AW'(1);
  localparam logic [AW-1:0] CAP  = AW'(PQ_CAPACITY);

  typedef logic [W-1:0] entry_t;
  typedef enum logic [2:0] {
    IDLE, UP_RD, UP_CMP, UP_FIN, DN_LOAD, DN_RDL, DN_RDR, DN_CMP
  } state_t;

  function automatic logic [KEY_W-1:0] key_of(input entry_t e);
    return e[W-1 -: KEY_W];
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] cur_q, cur_d;
  entry_t        item_q, item_d;
  entry_t        left_q, left_d;
  logic          has_r_q, has_r_d;
  entry_t        kvo_q;

  logic          we_c;
  logic [AW-1:0] wa_c, ra_c;
  entry_t        wd_c;

  // Child indices need one extra bit so 2*cur+1 never wraps.
  logic [AW:0]   c2, c2p1;
  logic          take_r;
  entry_t        child;
  logic [AW-1:0] child_idx;

  assign c2        = {cur_q, 1'b0};
  assign c2p1      = {cur_q, 1'b1};
  assign take_r    = has_r_q && (key_of(bus.mem_rd) < key_of(left_q));
  assign child     = take_r ? bus.mem_rd : left_q;
  assign child_idx = take_r ? c2p1[AW-1:0] : c2[AW-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cur_d   = cur_q;
    item_d  = item_q;
    left_d  = left_q;
    has_r_d = has_r_q;
    we_c    = 1'b0;
    wa_c    = '0;
    wd_c    = '0;
    ra_c    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.enq && bus.deq && count_q != '0) begin
          // Replace: new entry takes the root slot and sinks.
          item_d  = bus.kvi;
          cur_d   = ROOT;
          state_d = DN_RDL;
        end else if (bus.enq && count_q != CAP) begin
          item_d  = bus.kvi;
          cur_d   = count_q + 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == '0) begin
            we_c = 1'b1;
            wa_c = ROOT;
            wd_c = bus.kvi;
          end else begin
            state_d = UP_RD;
          end
        end else if (bus.deq && count_q != '0) begin
          count_d = count_q - 1'b1;
          if (count_q != ROOT) begin
            // Fetch the last entry; it becomes the item sifted from the root.
            ra_c    = count_q;
            state_d = DN_LOAD;
          end
        end
      end
      UP_RD: begin
        ra_c    = cur_q >> 1;
        state_d = UP_CMP;
      end
      UP_CMP: begin
        we_c = 1'b1;
        wa_c = cur_q;
        if (key_of(item_q) < key_of(bus.mem_rd)) begin
          wd_c    = bus.mem_rd;
          cur_d   = cur_q >> 1;
          state_d = ((cur_q >> 1) == ROOT) ? UP_FIN : UP_RD;
        end else begin
          wd_c    = item_q;
          state_d = IDLE;
        end
      end
      UP_FIN: begin
        we_c    = 1'b1;
        wa_c    = ROOT;
        wd_c    = item_q;
        state_d = IDLE;
      end
      DN_LOAD: begin
        item_d  = bus.mem_rd;
        cur_d   = ROOT;
        state_d = DN_RDL;
      end
      DN_RDL: begin
        if (c2 > {1'b0, count_q}) begin
          we_c    = 1'b1;
          wa_c    = cur_q;
          wd_c    = item_q;
          state_d = IDLE;
        end else begin
          ra_c    = c2[AW-1:0];
          state_d = DN_RDR;
        end
      end
      DN_RDR: begin
        left_d  = bus.mem_rd;
        has_r_d = (c2p1 <= {1'b0, count_q});
        if (c2p1 <= {1'b0, count_q}) ra_c = c2p1[AW-1:0];
        state_d = DN_CMP;
      end
      DN_CMP: begin
        we_c = 1'b1;
        wa_c = cur_q;
        if (key_of(child) < key_of(item_q)) begin
          wd_c    = child;
          cur_d   = child_idx;
          state_d = DN_RDL;
        end else begin
          wd_c    = item_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      cur_q   <= '0;
      item_q  <= '0;
      left_q  <= '0;
      has_r_q <= 1'b0;
      kvo_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cur_q   <= cur_d;
      item_q  <= item_d;
      left_q  <= left_d;
      has_r_q <= has_r_d;
      // Root mirror tracks every write to address 1.
      if (we_c && wa_c == ROOT) kvo_q <= wd_c;
    end
  end

  assign bus.kvo    = kvo_q;
  assign bus.full   = (count_q == CAP);
  assign bus.empty  = (count_q == '0);
  assign bus.busy   = (state_q != IDLE);
  assign bus.mem_ra = ra_c;
  // An enq arriving while reset is held must not reach the RAM.
  assign bus.mem_we = we_c & ~rst;
  assign bus.mem_wa = wa_c;
  assign bus.mem_wd = wd_c;
endmodule

// File: tb/tb_heap_pq_ctrl.sv
module tb_heap_pq_ctrl;
  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam int CAP   = 15;
  localparam int W     = KEY_W + VAL_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  heap_pq_ctrl_if #(.KEY_W(KEY_W), .VAL_W(VAL_W), .PQ_CAPACITY(CAP)) bus();

  heap_pq_ctrl #(.KEY_W(KEY_W), .VAL_W(VAL_W), .PQ_CAPACITY(CAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Synchronous RAM model plus a write counter.
  logic [W-1:0] ram [0:CAP];
  int wcnt = 0;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_wa] <= bus.mem_wd;
      wcnt <= wcnt + 1;
    end
    bus.mem_rd <= ram[bus.mem_ra];
  end

  int checks = 0;
  int failures = 0;
  logic [W-1:0] model[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_idx();
    int m = -1;
    for (int i = 0; i < model.size(); i++)
      if (m < 0 || model[i][W-1 -: KEY_W] < model[m][W-1 -: KEY_W]) m = i;
    return m;
  endfunction

  // Queue semantics straight from the request decode rules.
  task automatic model_apply(input logic e, input logic d, input logic [W-1:0] kv);
    int n = model.size();
    if (e && d && n != 0) begin
      model.delete(min_idx());
      model.push_back(kv);
    end else if (e && n != CAP) begin
      model.push_back(kv);
    end else if (d && n != 0) begin
      model.delete(min_idx());
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_empty"}, bus.empty, model.size() == 0);
    chk({tag, "_full"}, bus.full, model.size() == CAP);
    if (model.size() != 0)
      chk({tag, "_kvo"}, bus.kvo[W-1 -: KEY_W], model[min_idx()][W-1 -: KEY_W]);
  endtask

  task automatic op(input logic e, input logic d, input logic [W-1:0] kv,
                    input string tag, output int ncyc);
    int n = 0;
    @(negedge clk);
    bus.enq = e; bus.deq = d; bus.kvi = kv;
    @(negedge clk);
    bus.enq = 1'b0; bus.deq = 1'b0;
    model_apply(e, d, kv);
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({tag, "_timeout"}, bus.busy, 0);
    ncyc = n;
  endtask

  initial begin
    int n, w0, prev;
    logic [7:0] k;
    logic [7:0] exp_keys [0:4];
    exp_keys[0] = 8'd50; exp_keys[1] = 8'd40; exp_keys[2] = 8'd30;
    exp_keys[3] = 8'd20; exp_keys[4] = 8'd10;

    rst = 1'b1; bus.enq = 1'b0; bus.deq = 1'b0; bus.kvi = '0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_kvo", bus.kvo, 0);
    chk("rst_we", bus.mem_we, 0);
    @(negedge clk); rst = 1'b0;

    // Single enq into an empty queue: no sift.
    op(1'b1, 1'b0, 16'h3311, "first", n);
    chk("first_nobusy", n, 0);
    chk("first_kvo", bus.kvo, 16'h3311);
    check_state("first");
    op(1'b0, 1'b1, 16'h0, "first_deq", n);
    check_state("first_deq");

    // Descending keys: each one bubbles to the root.
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, {exp_keys[i], 8'(i)}, "desc", n);
      chk("desc_kvo", bus.kvo[W-1 -: KEY_W], exp_keys[i]);
      if (i > 0) chk("desc_busy", n > 0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'b1, 16'h0, "desc_deq", n);
      check_state("desc_deq");
    end

    // Random fill to capacity, refused enq, then sorted drain.
    for (int i = 0; i < CAP; i++) begin
      op(1'b1, 1'b0, {8'($urandom_range(0, 255)), 8'(i)}, "fill", n);
      check_state("fill");
    end
    chk("fill_full", bus.full, 1);
    w0 = wcnt;
    op(1'b1, 1'b0, 16'h0001, "enq_full", n);
    chk("enq_full_nowr", wcnt, w0);
    check_state("enq_full");
    prev = 0;
    for (int i = 0; i < CAP; i++) begin
      k = bus.kvo[W-1 -: KEY_W];
      chk("drain_order", int'(k) >= prev, 1);
      prev = int'(k);
      op(1'b0, 1'b1, 16'h0, "drain", n);
      check_state("drain");
    end
    chk("drain_empty", bus.empty, 1);

    w0 = wcnt;
    op(1'b0, 1'b1, 16'h0, "deq_empty", n);
    chk("deq_empty_nowr", wcnt, w0);
    check_state("deq_empty");

    // Replace on a 3-entry heap with root key 5.
    op(1'b1, 1'b0, 16'h0501, "rep_fill", n);
    op(1'b1, 1'b0, 16'h1402, "rep_fill", n);
    op(1'b1, 1'b0, 16'h1e03, "rep_fill", n);
    chk("rep_root", bus.kvo[W-1 -: KEY_W], 8'd5);
    op(1'b1, 1'b1, 16'h6304, "replace", n);
    check_state("replace");
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b1, 16'h0, "rep_deq", n);
      check_state("rep_deq");
    end

    // Requests pulsed while a sift-up runs are dropped.
    op(1'b1, 1'b0, 16'h4001, "bz_fill", n);
    @(negedge clk); bus.enq = 1'b1; bus.kvi = 16'h2002;
    @(negedge clk); bus.enq = 1'b0;
    model_apply(1'b1, 1'b0, 16'h2002);
    chk("bz_busy", bus.busy, 1);
    bus.enq = 1'b1; bus.deq = 1'b1; bus.kvi = 16'h0103;
    @(negedge clk); bus.enq = 1'b0; bus.deq = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("bz_done", bus.busy, 0);
    check_state("bz");
    for (int i = 0; i < 2; i++) begin
      op(1'b0, 1'b1, 16'h0, "bz_deq", n);
      check_state("bz_deq");
    end

    // Reset in the middle of a sift-down on an 8-entry heap.
    for (int i = 0; i < 8; i++)
      op(1'b1, 1'b0, {8'($urandom_range(10, 250)), 8'(i)}, "r8_fill", n);
    check_state("r8_fill");
    @(negedge clk); bus.deq = 1'b1;
    @(negedge clk); bus.deq = 1'b0;
    chk("r8_busy", bus.busy, 1);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model.delete();
    chk("r8_rst_busy", bus.busy, 0);
    chk("r8_rst_empty", bus.empty, 1);
    chk("r8_rst_kvo", bus.kvo, 0);
    @(negedge clk); rst = 1'b0;
    op(1'b1, 1'b0, 16'h0707, "r8_enq", n);
    chk("r8_enq_kvo", bus.kvo[W-1 -: KEY_W], 8'd7);
    check_state("r8_enq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
